// File: rtl/fm_stream_pkg.sv
// Shared types for the feature-map stream transmitter.
package fm_stream_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, RUN, DRAIN, DONE} fm_tx_state_e;

  localparam int DATA_W = 16;

endpackage

// File: rtl/fm_stream_tx.sv
// Reads one FM_WIDTH x FM_WIDTH frame from pixel memory in raster order and
// streams it to the window wrapper with a programmable inter-pixel gap.
module fm_stream_tx
  import fm_stream_pkg::*;
#(
  parameter int FM_DEPTH = 64,
  parameter int FM_WIDTH = 56,
  parameter int DATA_W   = fm_stream_pkg::DATA_W,
  parameter int ADDR_W   = 12,
  parameter int GAP_W    = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode_cfg,
  input  logic [GAP_W-1:0]           gap_cfg,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [FM_DEPTH*DATA_W-1:0] mem_rd_data,
  output logic                       verticle_sync,
  output logic                       mode_out,
  output logic                       data_out_valid,
  output logic signed [DATA_W-1:0]   data_out [FM_DEPTH]
);

  localparam int N = FM_WIDTH * FM_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  fm_tx_state_e               state_q, state_d;
  logic                       mode_lat_q, mode_lat_d;
  logic [GAP_W-1:0]           gap_lat_q, gap_lat_d;
  logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0]          next_addr_q, next_addr_d;
  logic                       rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
  logic                       vs_q, vs_d;
  logic                       mode_q, mode_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic [FM_DEPTH*DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mode_lat_q  <= 1'b0;
      gap_lat_q   <= '0;
      gap_cnt_q   <= '0;
      next_addr_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      vs_q        <= 1'b0;
      mode_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_lat_q  <= mode_lat_d;
      gap_lat_q   <= gap_lat_d;
      gap_cnt_q   <= gap_cnt_d;
      next_addr_q <= next_addr_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      vs_q        <= vs_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_lat_d  = mode_lat_q;
    gap_lat_d   = gap_lat_q;
    gap_cnt_d   = gap_cnt_q;
    next_addr_d = next_addr_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    vs_d        = 1'b0;
    mode_d      = mode_q;
    valid_d     = rd_en_q;
    done_d      = 1'b0;
    data_d      = rd_en_q ? mem_rd_data : data_q;

    // Abort drops any read still in flight so its pixel never reaches the wrapper.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
      data_d  = data_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = SYNC;
            mode_lat_d = mode_cfg;
            gap_lat_d  = gap_cfg;
          end
        end
        SYNC: begin
          state_d     = RUN;
          vs_d        = 1'b1;
          mode_d      = mode_lat_q;
          gap_cnt_d   = '0;
          next_addr_d = '0;
        end
        RUN: begin
          if (gap_cnt_q == '0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = next_addr_q;
            gap_cnt_d = gap_lat_q;
            if (next_addr_q == LAST_ADDR) begin
              state_d = DRAIN;
            end else begin
              next_addr_d = next_addr_q + ADDR_W'(1);
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        DRAIN: state_d = DONE;
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign mem_rd_en      = rd_en_q;
  assign mem_rd_addr    = rd_addr_q;
  assign verticle_sync  = vs_q;
  assign mode_out       = mode_q;
  assign data_out_valid = valid_q;

  for (genvar gi = 0; gi < FM_DEPTH; gi++) begin : g_lane
    assign data_out[gi] = data_q[gi*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_fm_stream_tx.sv
// Scoreboard bench: a small 4x4x2 instance and a default 56x56x64 instance.
module tb_fm_stream_tx;

  localparam int SW = 4;
  localparam int SD = 2;
  localparam int SN = SW * SW;
  localparam int LW = 56;
  localparam int LD = 64;
  localparam int LN = LW * LW;

  localparam int P_BUSY_S  = 0;
  localparam int P_MODE_S  = 1;
  localparam int P_DATA0_S = 2;
  localparam int P_DATA1_S = 3;
  localparam int P_RDEN_S  = 4;
  localparam int P_ADDR_S  = 5;
  localparam int P_VALID_S = 6;
  localparam int P_VS_S    = 7;
  localparam int P_DONE_S  = 8;
  localparam int P_BUSY_L  = 9;
  localparam int P_MODE_L  = 10;
  localparam int P_DATA0_L = 11;
  localparam int P_RDEN_L  = 12;
  localparam int P_VALID_L = 13;
  localparam int P_VS_L    = 14;
  localparam int P_QLEFT   = 15;

  typedef struct { int cyc; int l0; int l1; } exp_t;
  typedef struct { int cyc; int kind; int exp; } probe_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t   vq [2][$];
  int     evq[4][$];
  probe_t probes[$];

  // small instance
  logic              rstn_s, start_s, abort_s, mode_s;
  logic [3:0]        gap_s;
  logic              busy_s, done_s, rden_s, vs_s, mo_s, val_s;
  logic [11:0]       addr_s;
  logic [SD*16-1:0]  mdata_s;
  logic signed [15:0] dout_s [SD];

  // default-size instance
  logic              rstn_l, start_l, abort_l, mode_l;
  logic [3:0]        gap_l;
  logic              busy_l, done_l, rden_l, vs_l, mo_l, val_l;
  logic [11:0]       addr_l;
  logic [LD*16-1:0]  mdata_l;
  logic signed [15:0] dout_l [LD];

  for (genvar gi = 0; gi < SD; gi++) begin : g_mem_s
    assign mdata_s[gi*16 +: 16] = 16'(int'(addr_s) * 4 + gi);
  end
  for (genvar gi = 0; gi < LD; gi++) begin : g_mem_l
    assign mdata_l[gi*16 +: 16] = 16'(int'(addr_l) * 4 + gi);
  end

  fm_stream_tx #(.FM_DEPTH(SD), .FM_WIDTH(SW), .DATA_W(16), .ADDR_W(12), .GAP_W(4)) dut_s (
    .clk(clk), .rstn(rstn_s), .start(start_s), .abort(abort_s), .mode_cfg(mode_s),
    .gap_cfg(gap_s), .busy(busy_s), .done(done_s), .mem_rd_en(rden_s),
    .mem_rd_addr(addr_s), .mem_rd_data(mdata_s), .verticle_sync(vs_s),
    .mode_out(mo_s), .data_out_valid(val_s), .data_out(dout_s)
  );

  fm_stream_tx #(.FM_DEPTH(LD), .FM_WIDTH(LW), .DATA_W(16), .ADDR_W(12), .GAP_W(4)) dut_l (
    .clk(clk), .rstn(rstn_l), .start(start_l), .abort(abort_l), .mode_cfg(mode_l),
    .gap_cfg(gap_l), .busy(busy_l), .done(done_l), .mem_rd_en(rden_l),
    .mem_rd_addr(addr_l), .mem_rd_data(mdata_l), .verticle_sync(vs_l),
    .mode_out(mo_l), .data_out_valid(val_l), .data_out(dout_l)
  );

  function automatic bit ev_bit(int ch);
    case (ch)
      0:       return vs_s;
      1:       return done_s;
      2:       return vs_l;
      default: return done_l;
    endcase
  endfunction

  function automatic string ev_name(int ch);
    case (ch)
      0:       return "s_vsync";
      1:       return "s_done";
      2:       return "l_vsync";
      default: return "l_done";
    endcase
  endfunction

  function automatic int v_lane(int c, int w);
    if (c == 0) return (w == 0) ? int'(dout_s[0]) : int'(dout_s[1]);
    return (w == 0) ? int'(dout_l[0]) : int'(dout_l[LD-1]);
  endfunction

  function automatic int probe_act(int k);
    case (k)
      P_BUSY_S:  return int'(busy_s);
      P_MODE_S:  return int'(mo_s);
      P_DATA0_S: return int'(dout_s[0]);
      P_DATA1_S: return int'(dout_s[1]);
      P_RDEN_S:  return int'(rden_s);
      P_ADDR_S:  return int'(addr_s);
      P_VALID_S: return int'(val_s);
      P_VS_S:    return int'(vs_s);
      P_DONE_S:  return int'(done_s);
      P_BUSY_L:  return int'(busy_l);
      P_MODE_L:  return int'(mo_l);
      P_DATA0_L: return int'(dout_l[0]);
      P_RDEN_L:  return int'(rden_l);
      P_VALID_L: return int'(val_l);
      P_VS_L:    return int'(vs_l);
      default:   return vq[0].size() + vq[1].size() + evq[0].size() + evq[1].size()
                        + evq[2].size() + evq[3].size();
    endcase
  endfunction

  function automatic string probe_name(int k);
    case (k)
      P_BUSY_S:  return "s_busy";
      P_MODE_S:  return "s_mode_out";
      P_DATA0_S: return "s_data_lane0";
      P_DATA1_S: return "s_data_lane1";
      P_RDEN_S:  return "s_mem_rd_en";
      P_ADDR_S:  return "s_mem_rd_addr";
      P_VALID_S: return "s_valid";
      P_VS_S:    return "s_vsync_level";
      P_DONE_S:  return "s_done_level";
      P_BUSY_L:  return "l_busy";
      P_MODE_L:  return "l_mode_out";
      P_DATA0_L: return "l_data_lane0";
      P_RDEN_L:  return "l_mem_rd_en";
      P_VALID_L: return "l_valid";
      P_VS_L:    return "l_vsync_level";
      default:   return "leftover_expectations";
    endcase
  endfunction

  // Monitor: pops expected events as the DUTs present them; also evaluates probes.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   a0, a1, act;
    for (int c = 0; c < 2; c++) begin
      while (vq[c].size() > 0 && vq[c][0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL %s_pixel missing: required cyc=%0d lanes=%0d,%0d actual none",
                 c == 0 ? "s" : "l", vq[c][0].cyc, vq[c][0].l0, vq[c][0].l1);
        void'(vq[c].pop_front());
      end
      if ((c == 0) ? val_s : val_l) begin
        checks++;
        a0 = v_lane(c, 0);
        a1 = v_lane(c, 1);
        if (vq[c].size() > 0 && vq[c][0].cyc == cyc) begin
          e = vq[c].pop_front();
          if (a0 != e.l0 || a1 != e.l1) begin
            errors++;
            $display("FAIL %s_pixel cyc=%0d actual lanes=%0d,%0d required lanes=%0d,%0d",
                     c == 0 ? "s" : "l", cyc, a0, a1, e.l0, e.l1);
          end
        end else begin
          errors++;
          $display("FAIL %s_pixel unexpected valid cyc=%0d lanes=%0d,%0d required none",
                   c == 0 ? "s" : "l", cyc, a0, a1);
        end
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      while (evq[ch].size() > 0 && evq[ch][0] < cyc) begin
        checks++; errors++;
        $display("FAIL %s missing: required cyc=%0d actual none", ev_name(ch), evq[ch][0]);
        void'(evq[ch].pop_front());
      end
      if (ev_bit(ch)) begin
        checks++;
        if (evq[ch].size() > 0 && evq[ch][0] == cyc) void'(evq[ch].pop_front());
        else begin
          errors++;
          $display("FAIL %s unexpected actual cyc=%0d required none", ev_name(ch), cyc);
        end
      end
    end
    for (int i = probes.size() - 1; i >= 0; i--) begin
      if (probes[i].cyc == cyc) begin
        act = probe_act(probes[i].kind);
        checks++;
        if (act != probes[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                   probe_name(probes[i].kind), cyc, act, probes[i].exp);
        end
        probes.delete(i);
      end
    end
  end

  task automatic add_probe(input int c, input int k, input int e);
    probes.push_back(probe_t'{c, k, e});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge: start is sampled at edge t.
  task automatic start_s_frame(input bit m, input int g, input int npix, input bit exp_done,
                               output int t);
    start_s = 1'b1; mode_s = m; gap_s = 4'(g);
    t = cyc + 1;
    evq[0].push_back(t + 1);
    add_probe(t + 2, P_MODE_S, int'(m));
    for (int i = 0; i < npix; i++) vq[0].push_back(exp_t'{t + 3 + i * (g + 1), 4 * i, 4 * i + 1});
    if (exp_done) evq[1].push_back(t + 3 + (SN - 1) * (g + 1) + 1);
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic start_l_frame(input bit m, input int g, input int npix, input bit exp_done,
                               output int t);
    start_l = 1'b1; mode_l = m; gap_l = 4'(g);
    t = cyc + 1;
    evq[2].push_back(t + 1);
    add_probe(t + 2, P_MODE_L, int'(m));
    for (int i = 0; i < npix; i++) vq[1].push_back(exp_t'{t + 3 + i * (g + 1), 4 * i, 4 * i + LD - 1});
    if (exp_done) evq[3].push_back(t + 3 + (LN - 1) * (g + 1) + 1);
    @(negedge clk);
    start_l = 1'b0;
  endtask

  initial begin : stim
    int t, r;
    rstn_s = 1'b0; start_s = 1'b1; abort_s = 1'b0; mode_s = 1'b1; gap_s = 4'd0;
    rstn_l = 1'b0; start_l = 1'b1; abort_l = 1'b0; mode_l = 1'b1; gap_l = 4'd0;

    // reset held with start asserted
    for (int c = 1; c <= 2; c++) begin
      add_probe(c, P_BUSY_S, 0);  add_probe(c, P_RDEN_S, 0);  add_probe(c, P_VALID_S, 0);
      add_probe(c, P_VS_S, 0);    add_probe(c, P_DONE_S, 0);  add_probe(c, P_MODE_S, 0);
      add_probe(c, P_DATA0_S, 0); add_probe(c, P_BUSY_L, 0);  add_probe(c, P_RDEN_L, 0);
    end
    wait_until(2);
    rstn_s = 1'b1; rstn_l = 1'b1; start_s = 1'b0; start_l = 1'b0;
    @(negedge clk);

    // gap 0, mode 1: contiguous pixels
    start_s_frame(1'b1, 0, SN, 1'b1, t);
    add_probe(t, P_BUSY_S, 1);
    wait_until(t + 20);

    // gap 7 with a start attempt mid-frame that must be ignored
    start_s_frame(1'b1, 7, SN, 1'b1, t);
    add_probe(t + 3, P_RDEN_S, 0);
    add_probe(t + 20, P_DATA0_S, 8);
    add_probe(t + 26, P_DATA1_S, 9);
    add_probe(t + 30, P_MODE_S, 1);
    add_probe(t + 125, P_DATA0_S, 60);
    add_probe(t + 125, P_MODE_S, 1);
    wait_until(t + 4);
    start_s = 1'b1; mode_s = 1'b0; gap_s = 4'd3;
    @(negedge clk);
    start_s = 1'b0;
    wait_until(t + 126);

    // abort coincident with the 5th read, then a fresh frame
    start_s_frame(1'b0, 2, 4, 1'b0, t);
    add_probe(t + 14, P_RDEN_S, 1);
    add_probe(t + 14, P_ADDR_S, 4);
    add_probe(t + 15, P_BUSY_S, 0);
    add_probe(t + 15, P_VALID_S, 0);
    wait_until(t + 14);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    wait_until(t + 30);
    start_s_frame(1'b1, 0, SN, 1'b1, t);
    wait_until(t + 22);

    // default size: reset lands on pixel 1000, then a complete frame
    start_l_frame(1'b1, 7, 1000, 1'b0, t);
    r = t + 3 + 1000 * 8;
    wait_until(r - 1);
    add_probe(r, P_BUSY_L, 0);  add_probe(r, P_VALID_L, 0); add_probe(r, P_RDEN_L, 0);
    add_probe(r, P_MODE_L, 0);  add_probe(r, P_DATA0_L, 0); add_probe(r, P_VS_L, 0);
    rstn_l = 1'b0;
    @(negedge clk);
    rstn_l = 1'b1;
    @(negedge clk);
    start_l_frame(1'b0, 7, LN, 1'b1, t);
    wait_until(t + 3 + (LN - 1) * 8 + 3);

    add_probe(cyc + 1, P_QLEFT, 0);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
